// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel filter.
// Holds the FSM state encoding, a width helper and the kernel weights.
package sobel_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Sobel weights: outer taps 1, centre tap 2
   localparam int KC_EDGE = 1;
   localparam int KC_MID  = 2;

   // Ceiling log2, usable in parameter expressions
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational Sobel magnitude over the eight neighbours of a 3x3 window.
// Result is (|Gx|+|Gy|) >> MAG_SHIFT, saturated to the pixel width.
module sobel_kernel
   import sobel_pkg::*;
#(
   parameter int unsigned DWIDTH    = 8,
   parameter int unsigned MAG_SHIFT = 1
) (
   input  logic [DWIDTH-1:0] tl,
   input  logic [DWIDTH-1:0] tm,
   input  logic [DWIDTH-1:0] tr,
   input  logic [DWIDTH-1:0] ml,
   input  logic [DWIDTH-1:0] mr,
   input  logic [DWIDTH-1:0] bl,
   input  logic [DWIDTH-1:0] bm,
   input  logic [DWIDTH-1:0] br,
   output logic [DWIDTH-1:0] mag
);

   localparam int unsigned SW = DWIDTH + 4;

   logic signed [SW-1:0] gx, gy;
   logic [SW-1:0] ax, ay, sum, shifted;

   function automatic logic signed [SW-1:0] ext(input logic [DWIDTH-1:0] p);
      return $signed(SW'(p));
   endfunction

   always_comb begin
      gx = SW'(KC_EDGE) * (ext(tr) - ext(tl))
         + SW'(KC_MID)  * (ext(mr) - ext(ml))
         + SW'(KC_EDGE) * (ext(br) - ext(bl));
      gy = SW'(KC_EDGE) * (ext(bl) - ext(tl))
         + SW'(KC_MID)  * (ext(bm) - ext(tm))
         + SW'(KC_EDGE) * (ext(br) - ext(tr));
      ax = gx[SW-1] ? unsigned'(-gx) : unsigned'(gx);
      ay = gy[SW-1] ? unsigned'(-gy) : unsigned'(gy);
      sum = ax + ay;
      shifted = sum >> MAG_SHIFT;
      mag = (|shifted[SW-1:DWIDTH]) ? {DWIDTH{1'b1}} : shifted[DWIDTH-1:0];
   end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter between an upstream FWFT FIFO and a downstream FIFO.
// Emits one pixel per input pixel; border centres are zero, frame tail is flushed.
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int unsigned DWIDTH     = 8,
   parameter int unsigned IMG_WIDTH  = 720,
   parameter int unsigned IMG_HEIGHT = 540,
   parameter int unsigned MAG_SHIFT  = 1
) (
   input  logic              clock,
   input  logic              reset,
   output logic              in_rd_en,
   input  logic [DWIDTH-1:0] in_dout,
   input  logic              in_empty,
   output logic              out_wr_en,
   output logic [DWIDTH-1:0] out_din,
   input  logic              out_full,
   input  logic [DWIDTH-1:0] threshold,
   input  logic              binary_en,
   output logic              frame_done
);

   localparam int unsigned W    = IMG_WIDTH;
   localparam int unsigned H    = IMG_HEIGHT;
   localparam int unsigned NPIX = W * H;
   localparam int unsigned LBN  = 2 * W + 2;
   localparam int unsigned KW   = clog2(NPIX + 1);
   localparam int unsigned CXW  = clog2(W);
   localparam int unsigned CYW  = clog2(H);
   localparam int unsigned FW   = clog2(W + 1);

   state_t state, state_nx;

   logic [DWIDTH-1:0] lb [LBN];
   logic [KW-1:0]     k;
   logic [CXW-1:0]    cx;
   logic [CYW-1:0]    cy;
   logic [FW-1:0]     fcnt;
   logic [DWIDTH-1:0] thr_q;
   logic              bin_q;
   logic [DWIDTH-1:0] mag_c;
   logic              border_c;

   always_ff @(posedge clock) begin
      if (!reset) state <= FILL;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         FILL:    if (in_rd_en && k == KW'(W))        state_nx = RUN;
         RUN:     if (in_rd_en && k == KW'(NPIX - 1)) state_nx = FLUSH;
         FLUSH:   if (frame_done)                     state_nx = FILL;
         default:                                     state_nx = FILL;
      endcase
   end

   // Handshake strobes are gated off entirely while reset is held low
   always_comb begin
      in_rd_en   = 1'b0;
      out_wr_en  = 1'b0;
      frame_done = 1'b0;
      if (reset) begin
         case (state)
            FILL:  in_rd_en = !in_empty;
            RUN: begin
               in_rd_en  = !in_empty && !out_full;
               out_wr_en = !in_empty && !out_full;
            end
            FLUSH: begin
               out_wr_en  = !out_full;
               frame_done = !out_full && (fcnt == FW'(W));
            end
            default: ;
         endcase
      end
   end

   // Counters and per-frame mode latch; (cx,cy) tracks the current output centre
   always_ff @(posedge clock) begin
      if (!reset) begin
         k     <= '0;
         cx    <= '0;
         cy    <= '0;
         fcnt  <= '0;
         thr_q <= '0;
         bin_q <= 1'b0;
      end else if (!(state inside {FILL, RUN, FLUSH}) || frame_done) begin
         k    <= '0;
         cx   <= '0;
         cy   <= '0;
         fcnt <= '0;
      end else begin
         if (state == FILL && k == '0) begin
            thr_q <= threshold;
            bin_q <= binary_en;
         end
         if (in_rd_en) k <= k + KW'(1);
         if (state == RUN && out_wr_en) begin
            if (cx == CXW'(W - 1)) begin
               cx <= '0;
               cy <= cy + CYW'(1);
            end else begin
               cx <= cx + CXW'(1);
            end
         end
         if (state == FLUSH && out_wr_en) fcnt <= fcnt + FW'(1);
      end
   end

   // Two lines plus two pixels of history; never cleared, FILL overwrites it
   always_ff @(posedge clock) begin
      if (in_rd_en) begin
         lb[0] <= in_dout;
         for (int i = 1; i < int'(LBN); i++) lb[i] <= lb[i-1];
      end
   end

   sobel_kernel #(
      .DWIDTH    (DWIDTH),
      .MAG_SHIFT (MAG_SHIFT)
   ) u_kernel (
      .tl  (lb[2*W+1]),
      .tm  (lb[2*W]),
      .tr  (lb[2*W-1]),
      .ml  (lb[W+1]),
      .mr  (lb[W-1]),
      .bl  (lb[1]),
      .bm  (lb[0]),
      .br  (in_dout),
      .mag (mag_c)
   );

   assign border_c = (cx == '0) || (cx == CXW'(W - 1)) || (cy == '0) || (cy == CYW'(H - 1));

   always_comb begin
      out_din = '0;
      if (state == RUN && !border_c) begin
         if (bin_q) out_din = (mag_c >= thr_q) ? {DWIDTH{1'b1}} : '0;
         else       out_din = mag_c;
      end
   end

endmodule
